mem_port_arb: RTL and testbench
===============================

Name: mem_port_arb

Overview:
- Arbitrates the single data-memory port between the MR stage (load reads) and the MW stage (store writes) of the x86 pipeline.
- Sequences each access through a multi-cycle req/ready handshake and generates per-stage stall signals.
- Consumes the existing mem_dep flag: a read flagged as dependent on an in-flight store is never granted.
- Writes win ties; a saturating starvation counter guarantees reads eventual service.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_WAIT, 4, cycles an eligible read may lose arbitration before it gets forced priority. Legal range is 1..15.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- mr_v  in  1  MR stage valid.
- mr_re  in  1  MR stage reads memory.
- mr_addr  in  ADDR_W  read address.
- mem_dep  in  1  read depends on a pending store; blocks the read grant.
- mw_v  in  1  MW stage valid.
- mw_we  in  1  MW stage writes memory.
- mw_addr  in  ADDR_W  write address.
- mw_data  in  DATA_W  write data.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  1=write, 0=read, registered.
- mem_addr  out  ADDR_W  registered.
- mem_wdata  out  DATA_W  registered.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_rdata  in  DATA_W  read data, valid when mem_ready=1.
- mr_rdata  out  DATA_W  latched read data.
- mr_done  out  1  one-cycle pulse: read complete, mr_rdata valid.
- mw_done  out  1  one-cycle pulse: write complete.
- mr_stall  out  1  combinational: hold MR stage.
- mw_stall  out  1  combinational: hold MW stage.

Behaviour:
- Request definitions:
  - rd_raw = mr_v & mr_re.
  - rd_elig = rd_raw & !mem_dep.
  - wr_req = mw_v & mw_we.
- State machine states: IDLE, RD_BUSY, WR_BUSY.
- IDLE transitions:
  - Grant to write if wr_req and (!rd_elig or starve_cnt < MAX_WAIT). Go to WR_BUSY. Latch mem_we=1, mem_addr=mw_addr, mem_wdata=mw_data. Set mem_req=1 from the next cycle.
  - Otherwise, if rd_elig, grant to read. Go to RD_BUSY. Latch mem_we=0, mem_addr=mr_addr. mem_wdata is unchanged.
  - With no request, stay in IDLE with mem_req=0.
- RD_BUSY / WR_BUSY:
  - Hold mem_req=1 and all mem_* outputs stable until mem_ready is sampled high.
  - On that edge: mem_req goes to 0 and state returns to IDLE.
  - For a read, mr_rdata <= mem_rdata and mr_done=1 the following cycle; for a write, mw_done=1 the following cycle.
  - Minimum access time is 3 cycles: grant, req with ready, done. At least one IDLE cycle separates transactions.
- mem_ready sampled while in IDLE is ignored, with no state or output change.
- Stalls:
  - mr_stall = rd_raw & !mr_done.
  - mw_stall = wr_req & !mw_done.
  - A stalled stage holds its inputs stable. Inputs are captured only at grant.
- starve_cnt (4 bits):
  - Increments, saturating at MAX_WAIT, in each IDLE cycle where rd_elig is high and the write is granted.
  - Cleared on read grant, or in any cycle where rd_elig=0.
  - Not changed in BUSY states.
- Flush while busy (request dropped mid-transaction): the transaction still completes and the done pulse still fires. Stall outputs follow the current inputs.
- mem_dep rising while a read is already in RD_BUSY has no effect on that read.
- Reset (synchronous, takes priority over everything, including mid-transaction):
  - Next state is IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mr_rdata=0, mr_done=0, mw_done=0, starve_cnt=0.
  - The in-flight transaction is abandoned, and a subsequent mem_ready is ignored.
- mr_done and mw_done are never high together. At most one transaction is outstanding.

Test Plan:
1. Single read: mr_v=mr_re=1, mr_addr=0x1000, mem_ready high 2 cycles after mem_req rises, mem_rdata=0xDEADBEEF -> mem_req=1 with mem_we=0 and mem_addr=0x1000 at cycle 1. mr_done pulses one cycle after ready, mr_rdata=0xDEADBEEF. mr_stall falls in the same cycle as mr_done.
2. Simultaneous requests: read 0x2000 and write 0x3000/0x55 in the same cycle, ready=1 immediately -> write is issued first (mem_we=1, mem_addr=0x3000, mem_wdata=0x55), mw_done pulses, then the read of 0x2000 issues. mr_stall stays high throughout the write.
3. Starvation, MAX_WAIT=4: read held eligible while a new write is presented every IDLE cycle -> exactly 4 writes are granted, the 5th grant goes to the read, and starve_cnt returns to 0.
4. Dependency block: rd_raw=1 with mem_dep=1 for 6 cycles, no writes -> mem_req stays 0, mr_stall=1, starve_cnt=0. When mem_dep falls, the read is granted the next cycle.
5. Reset mid-read: reset asserted while in RD_BUSY, then mem_ready pulses 1 cycle after reset releases -> mem_req=0 the cycle after reset, no mr_done, mr_rdata=0, state IDLE.
6. Spurious ready: mem_ready=1 in IDLE with no requests -> no done pulse, all outputs unchanged.

Source files
------------

// File: rtl/mem_port_arb.sv
// ---------------------------------------------------------------------------
// mem_port_arb
//
// Shares the single data-memory port between the MR stage (load reads) and
// the MW stage (store writes). Each granted access runs a registered
// req/ready handshake. Per-stage stall outputs hold a stage until its done
// pulse. Writes win ties. A saturating starvation counter forces a read
// through once it has lost MAX_WAIT arbitrations in a row.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   mr_v, mr_re, mr_addr  MR stage read request
//   mem_dep               read depends on a pending store (never granted)
//   mw_v, mw_we, mw_addr,
//   mw_data               MW stage write request
//   mem_req, mem_we,
//   mem_addr, mem_wdata   registered memory request
//   mem_ready, mem_rdata  memory completion and read data
//   mr_rdata, mr_done     latched read data and read-complete pulse
//   mw_done               write-complete pulse
//   mr_stall, mw_stall    combinational stage holds
// ---------------------------------------------------------------------------
module mem_port_arb #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mr_v,
  input  logic              mr_re,
  input  logic [ADDR_W-1:0] mr_addr,
  input  logic              mem_dep,
  input  logic              mw_v,
  input  logic              mw_we,
  input  logic [ADDR_W-1:0] mw_addr,
  input  logic [DATA_W-1:0] mw_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mr_rdata,
  output logic              mr_done,
  output logic              mw_done,
  output logic              mr_stall,
  output logic              mw_stall
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_BUSY = 2'd1;
  localparam logic [1:0] WR_BUSY = 2'd2;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [1:0] state;
  logic [3:0] starve_cnt;

  logic rd_raw;
  logic rd_elig;
  logic wr_req;
  logic arb_open;
  logic grant_wr;
  logic grant_rd;

  // Request qualification. A dependent read still stalls its stage but is
  // never eligible for a grant.
  assign rd_raw  = mr_v & mr_re;
  assign rd_elig = rd_raw & ~mem_dep;
  assign wr_req  = mw_v & mw_we;

  // During a done cycle the finished stage still presents its old request
  // (it only advances at the end of that cycle), so no grant is made then.
  // This is also what keeps one idle cycle between transactions.
  assign arb_open = (state == IDLE) & ~mr_done & ~mw_done;

  // Writes win unless the eligible read has already lost MAX_WAIT times.
  assign grant_wr = arb_open & wr_req & (~rd_elig | (starve_cnt < MAX_WAIT_C));
  assign grant_rd = arb_open & rd_elig & ~grant_wr;

  // Stalls drop in the cycle the done pulse is visible so the stage can move.
  assign mr_stall = rd_raw & ~mr_done;
  assign mw_stall = wr_req & ~mw_done;

  // Main transaction sequencer: latch the winner's request at grant, hold
  // the memory-side outputs stable while busy, and retire on mem_ready.
  // mem_ready seen in IDLE falls through to no action.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mr_rdata  <= '0;
      mr_done   <= 1'b0;
      mw_done   <= 1'b0;
    end else begin
      mr_done <= 1'b0;
      mw_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_wr) begin
            state     <= WR_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= mw_addr;
            mem_wdata <= mw_data;
          end else if (grant_rd) begin
            state    <= RD_BUSY;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= mr_addr;
          end
        end
        RD_BUSY: begin
          if (mem_ready) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mr_rdata <= mem_rdata;
            mr_done  <= 1'b1;
          end
        end
        WR_BUSY: begin
          if (mem_ready) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mw_done <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  // Starvation counter: counts consecutive write wins over an eligible read,
  // saturating at MAX_WAIT. It is frozen while a transaction is in flight so
  // that a run of back-to-back writes keeps accumulating.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (state == IDLE) begin
      if (!rd_elig || grant_rd) begin
        starve_cnt <= 4'd0;
      end else if (grant_wr && (starve_cnt < MAX_WAIT_C)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arb
//
// Directed bench for mem_port_arb. Stimulus pushes the expected memory
// transactions and read results into queues. A negedge monitor pops them
// whenever the DUT completes a handshake or pulses mr_done.
// ---------------------------------------------------------------------------
module tb_mem_port_arb;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xact_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        mr_v, mr_re, mem_dep, mw_v, mw_we, mem_ready;
  logic [31:0] mr_addr, mw_addr, mw_data, mem_rdata;
  logic        mem_req, mem_we, mr_done, mw_done, mr_stall, mw_stall;
  logic [31:0] mem_addr, mem_wdata, mr_rdata;

  xact_t       exp_q[$];
  logic [31:0] rd_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  mem_port_arb #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .mr_v(mr_v), .mr_re(mr_re), .mr_addr(mr_addr), .mem_dep(mem_dep),
    .mw_v(mw_v), .mw_we(mw_we), .mw_addr(mw_addr), .mw_data(mw_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mr_rdata(mr_rdata), .mr_done(mr_done), .mw_done(mw_done),
    .mr_stall(mr_stall), .mw_stall(mw_stall)
  );

  always #5 clk = ~clk;

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no_finish required finish");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for mem_req, hold off `delay` cycles, then complete it.
  // Returns just after the edge that sampled mem_ready.
  task automatic serve_mem(input int delay, input logic [31:0] rdata);
    int n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    check_output("req_seen", {63'd0, mem_req}, 64'd1);
    repeat (delay) tick();
    mem_ready = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic apply_stimulus(input logic rv, input logic [31:0] ra, input logic dep,
                                input logic wv, input logic [31:0] wa, input logic [31:0] wd);
    mr_v    = rv;
    mr_re   = rv;
    mr_addr = ra;
    mem_dep = dep;
    mw_v    = wv;
    mw_we   = wv;
    mw_addr = wa;
    mw_data = wd;
  endtask

  // Scoreboard monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (!reset && mem_req && mem_ready) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_xact", {31'd0, mem_we, mem_addr}, 64'd0);
      end else begin
        xact_t e;
        e = exp_q.pop_front();
        check_output("xact_we",    {63'd0, mem_we}, {63'd0, e.we});
        check_output("xact_addr",  {32'd0, mem_addr}, {32'd0, e.addr});
        check_output("xact_wdata", {32'd0, mem_wdata}, {32'd0, e.wdata});
      end
    end
    if (mr_done) begin
      if (rd_q.size() == 0) begin
        check_output("unexpected_mr_done", {63'd0, mr_done}, 64'd0);
      end else begin
        check_output("mr_rdata", {32'd0, mr_rdata}, {32'd0, rd_q.pop_front()});
      end
    end
    if (mr_done && mw_done) check_output("both_done", 64'd1, 64'd0);
  end

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = '0;
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) tick();
    check_output("rst_mem_req",   {63'd0, mem_req}, 64'd0);
    check_output("rst_mem_we",    {63'd0, mem_we}, 64'd0);
    check_output("rst_mem_addr",  {32'd0, mem_addr}, 64'd0);
    check_output("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
    check_output("rst_mr_rdata",  {32'd0, mr_rdata}, 64'd0);
    check_output("rst_done",      {62'd0, mr_done, mw_done}, 64'd0);
    reset = 1'b0;
    tick();

    // 1: single read
    $display("[TB] test 1: single read");
    apply_stimulus(1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, 32'h0);
    exp_q.push_back('{1'b0, 32'h1000, 32'h0});
    rd_q.push_back(32'hDEADBEEF);
    tick();
    check_output("t1_req_after_grant", {63'd0, mem_req}, 64'd1);
    check_output("t1_stall_busy", {63'd0, mr_stall}, 64'd1);
    serve_mem(2, 32'hDEADBEEF);
    check_output("t1_mr_done", {63'd0, mr_done}, 64'd1);
    check_output("t1_mr_stall", {63'd0, mr_stall}, 64'd0);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // 2: simultaneous read and write, write first
    $display("[TB] test 2: simultaneous requests");
    apply_stimulus(1'b1, 32'h2000, 1'b0, 1'b1, 32'h3000, 32'h55);
    exp_q.push_back('{1'b1, 32'h3000, 32'h55});
    exp_q.push_back('{1'b0, 32'h2000, 32'h55});
    rd_q.push_back(32'hCAFE0001);
    serve_mem(0, 32'h0);
    check_output("t2_mw_done", {63'd0, mw_done}, 64'd1);
    check_output("t2_mr_done", {63'd0, mr_done}, 64'd0);
    check_output("t2_mr_stall", {63'd0, mr_stall}, 64'd1);
    check_output("t2_mw_stall", {63'd0, mw_stall}, 64'd0);
    mw_v  = 1'b0;
    mw_we = 1'b0;
    serve_mem(0, 32'hCAFE0001);
    check_output("t2_rd_done", {63'd0, mr_done}, 64'd1);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // 3: starvation, MAX_WAIT=4
    $display("[TB] test 3: starvation");
    apply_stimulus(1'b1, 32'h4000, 1'b0, 1'b1, 32'h5000, 32'hA0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{1'b1, 32'h5000 + i, 32'hA0 + i});
    end
    exp_q.push_back('{1'b0, 32'h4000, 32'hA3});
    exp_q.push_back('{1'b1, 32'h5004, 32'hA4});
    rd_q.push_back(32'h44440000);
    for (int i = 0; i < 4; i++) begin
      serve_mem(0, 32'h0);
      check_output("t3_mw_done", {63'd0, mw_done}, 64'd1);
      check_output("t3_starve_cnt", {60'd0, dut.starve_cnt}, 64'(i + 1));
      mw_addr = 32'h5000 + i + 1;
      mw_data = 32'hA0 + i + 1;
    end
    serve_mem(0, 32'h44440000);
    check_output("t3_read_granted", {63'd0, mr_done}, 64'd1);
    check_output("t3_starve_clear", {60'd0, dut.starve_cnt}, 64'd0);
    mr_v  = 1'b0;
    mr_re = 1'b0;
    serve_mem(0, 32'h0);
    check_output("t3_last_write", {63'd0, mw_done}, 64'd1);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // 4: dependency block
    $display("[TB] test 4: dependency block");
    apply_stimulus(1'b1, 32'h6000, 1'b1, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_output("t4_no_req", {63'd0, mem_req}, 64'd0);
      check_output("t4_stall", {63'd0, mr_stall}, 64'd1);
    end
    check_output("t4_starve", {60'd0, dut.starve_cnt}, 64'd0);
    mem_dep = 1'b0;
    exp_q.push_back('{1'b0, 32'h6000, 32'hA4});
    rd_q.push_back(32'h600D600D);
    tick();
    check_output("t4_grant_next", {63'd0, mem_req}, 64'd1);
    serve_mem(1, 32'h600D600D);
    check_output("t4_done", {63'd0, mr_done}, 64'd1);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // 5: reset mid-read
    $display("[TB] test 5: reset mid-read");
    apply_stimulus(1'b1, 32'h7000, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check_output("t5_busy", {63'd0, mem_req}, 64'd1);
    reset = 1'b1;
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check_output("t5_req_cleared", {63'd0, mem_req}, 64'd0);
    reset = 1'b0;
    tick();
    mem_ready = 1'b1;
    mem_rdata = 32'h12345678;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    check_output("t5_no_done", {63'd0, mr_done}, 64'd0);
    check_output("t5_rdata_zero", {32'd0, mr_rdata}, 64'd0);
    check_output("t5_state_idle", {62'd0, dut.state}, 64'd0);
    tick();
    check_output("t5_no_done_late", {63'd0, mr_done}, 64'd0);

    // 6: spurious ready in IDLE
    $display("[TB] test 6: spurious ready");
    mem_ready = 1'b1;
    mem_rdata = 32'hBAD0BAD0;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    check_output("t6_done", {62'd0, mr_done, mw_done}, 64'd0);
    check_output("t6_req", {62'd0, mem_req, mem_we}, 64'd0);
    check_output("t6_addr", {32'd0, mem_addr}, 64'd0);
    check_output("t6_wdata", {32'd0, mem_wdata}, 64'd0);
    check_output("t6_rdata", {32'd0, mr_rdata}, 64'd0);
    tick();

    check_output("xact_queue_empty", 64'(exp_q.size()), 64'd0);
    check_output("rd_queue_empty", 64'(rd_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
